mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates between the instruction-fetch port and the data-bus port for one shared single-port synchronous SRAM, replacing the dual-port asynchronous-read array in the MCU memory subsystem. It grants one requester at a time using round-robin on contention. Word-wide accesses run directly. Byte and halfword stores run as an internal read-modify-write sequence, so the requesters see a simple req/ack protocol.

## Interface
- XLEN, 32, data and address width
- MEM_AW, 12, SRAM word-address width (4·2^MEM_AW bytes)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_ack_o
- if_addr_i  in  XLEN  fetch byte address; bits [1:0] ignored
- if_ack_o  out  1  one-cycle pulse; if_rdata_o valid in the same cycle
- if_rdata_o  out  XLEN  fetched instruction word
- d_req_i  in  1  data request; held with d_we_i, d_addr_i, d_wdata_i and d_sel_i until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  XLEN  data byte address; bits [1:0] ignored
- d_wdata_i  in  XLEN  store data, already lane-aligned
- d_sel_i  in  4  byte-lane enables
- d_ack_o  out  1  one-cycle completion pulse
- d_err_o  out  1  pulses with d_ack_o when the store has an illegal d_sel_i
- d_rdata_o  out  XLEN  load data, valid while d_ack_o is high
- d_busy_o  out  1  store in progress
- sram_ce_o  out  1  SRAM access enable
- sram_we_o  out  1  SRAM write; meaningful only while sram_ce_o is high
- sram_addr_o  out  MEM_AW  word address, taken from addr[MEM_AW+1:2]
- sram_wdata_o  out  XLEN  SRAM write data
- sram_rdata_i  in  XLEN  read data, valid one cycle after a ce=1, we=0 cycle

## Operation
- States: IDLE, IF_RD, D_RD, D_RMW, D_WACK.
- Requests are sampled only in IDLE. No grant is made in any ack cycle.
- Arbitration in IDLE:
  - Single requester: that requester is granted.
  - Both requesting: the port not granted last wins.
  - last_grant resets to "data", so fetch wins the first contention.
- On grant, the data-side addr, wdata and sel are latched into internal registers.
- Transitions and per-state actions:
  - IDLE, fetch granted: ce=1, we=0, addr from if_addr_i → IF_RD.
  - IDLE, data load granted: ce=1, we=0 → D_RD.
  - IDLE, store with sel=1111: ce=1, we=1, wdata=d_wdata_i → D_WACK.
  - IDLE, store with sel ∈ {0001, 0010, 0100, 1000, 0011, 1100}: ce=1, we=0 (read phase) → D_RMW.
  - IDLE, store with any other sel: no SRAM access, error flag set → D_WACK.
  - IF_RD: if_ack_o=1, if_rdata_o=sram_rdata_i → IDLE.
  - D_RD: d_ack_o=1, d_rdata_o=sram_rdata_i → IDLE.
  - D_RMW: ce=1, we=1, addr from the latched address, wdata = merge → D_WACK.
  - D_WACK: d_ack_o=1; d_err_o=error flag, which clears → IDLE.
- Merge rule: byte lane k = d_wdata[8k+7:8k] if sel[k]=1, else sram_rdata_i[8k+7:8k].
- Loads ignore d_sel_i. Byte and halfword extraction is done by the writeback stage.
- d_busy_o is high from the store grant cycle through the cycle before d_ack_o.
- Outside the actions listed above, all outputs are 0. Rdata outputs are 0 when not acking.

## Timing
- Reset (asynchronous) forces:
  - state IDLE, last_grant = data, error flag = 0;
  - all outputs 0, combinationally, while rst_n is low.
- Reset during any state aborts the access:
  - an SRAM write occurs only if its ce/we cycle completed before reset asserted;
  - no ack is issued for the aborted access.
- Latency from grant cycle N:
  - loads, fetches, full-word stores and illegal stores: ack at N+1;
  - partial stores: ack at N+2 (read at N, write at N+1).
- Throughput: at most one access per 2 cycles (3 for a partial store). The earliest next grant is the cycle after an ack.
- A requester may keep req high after its ack to issue a new request. The new request is evaluated at the next IDLE cycle.
- Request signals are sampled only in IDLE. Changes during other states are ignored.

## Test plan
- Reset, memory word 4 = 0x00000013; fetch req with if_addr_i=0x10 at cycle N → sram_ce_o=1 with addr 4 at N; if_ack_o=1 and if_rdata_o=0x00000013 at N+1.
- Fetch and data load requested in the same cycle after reset → fetch acked at N+1, load granted at N+2 and acked at N+3. A repeated contention then goes to fetch again.
- Store 0xDEADBEEF, sel=1111, to 0x20 → exactly one ce/we cycle; d_busy_o high in the grant cycle; d_ack_o at N+1. A following load from 0x20 returns 0xDEADBEEF.
- Word at 0x24 = 0x11223344; store sel=0100, wdata=0x00AB0000 → one read cycle, then one write of 0x11AB3344, d_ack_o at N+2. A following load returns 0x11AB3344.
- Store sel=0101 → sram_ce_o stays 0; d_ack_o=1 and d_err_o=1 at N+1; memory unchanged.
- rst_n asserted while in D_RMW → no write cycle, no ack, all outputs 0. After release, a load from the same address returns the original value.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//
// Bundles the two requester ports (instruction fetch, data bus) and the
// shared single-port SRAM port of mem_port_arbiter.
//
// Ports / signals:
//   fetch  : if_req_i, if_addr_i -> if_ack_o, if_rdata_o
//   data   : d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i
//            -> d_ack_o, d_err_o, d_rdata_o, d_busy_o
//   sram   : sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o <- sram_rdata_i
//
// Modports:
//   slave  : the arbiter side (consumes requests, drives the SRAM)
//   master : the environment side (requesters plus the SRAM macro)

interface mem_port_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 12
) ();

    logic              if_req_i;
    logic [XLEN-1:0]   if_addr_i;
    logic              if_ack_o;
    logic [XLEN-1:0]   if_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [XLEN-1:0]   d_addr_i;
    logic [XLEN-1:0]   d_wdata_i;
    logic [3:0]        d_sel_i;
    logic              d_ack_o;
    logic              d_err_o;
    logic [XLEN-1:0]   d_rdata_o;
    logic              d_busy_o;

    logic              sram_ce_o;
    logic              sram_we_o;
    logic [MEM_AW-1:0] sram_addr_o;
    logic [XLEN-1:0]   sram_wdata_o;
    logic [XLEN-1:0]   sram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
        input  sram_rdata_i,
        output if_ack_o, if_rdata_o,
        output d_ack_o, d_err_o, d_rdata_o, d_busy_o,
        output sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
        output sram_rdata_i,
        input  if_ack_o, if_rdata_o,
        input  d_ack_o, d_err_o, d_rdata_o, d_busy_o,
        input  sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port synchronous SRAM between the instruction-fetch port
// and the data-bus port. One requester is served at a time; on contention the
// port that was not granted last wins. Full-word stores write directly, byte
// and aligned-halfword stores run as read-then-write, any other store lane
// mask is rejected with d_err_o and never reaches the SRAM.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset; all outputs forced to 0 while low
//   bus    : mem_port_arbiter_if.slave (fetch port, data port, SRAM port)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, arbitrate, issue first SRAM cycle of a grant
// IF_RD | fetch read data returning, pulse if_ack_o
// D_RD  | load read data returning, pulse d_ack_o
// D_RMW | partial store: old word returning, write merged word
// D_WACK| store complete (or rejected), pulse d_ack_o / d_err_o

module mem_port_arbiter #(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        D_RD   = 3'd2,
        D_RMW  = 3'd3,
        D_WACK = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_data_q, last_grant_data_d;
    logic              err_q, err_d;
    logic              capture;

    logic [MEM_AW-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        sel_q;

    logic              grant_if;
    logic              grant_d;
    logic [MEM_AW-1:0] if_word_addr;
    logic [MEM_AW-1:0] d_word_addr;

    logic              ce, we;
    logic [MEM_AW-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic              if_ack, d_ack, d_err, d_busy;
    logic [XLEN-1:0]   if_rdata, d_rdata;

    // Byte-lane bits and address bits above the SRAM range are don't-care.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.if_addr_i[XLEN-1:MEM_AW+2],
                                bus.d_addr_i[1:0],  bus.d_addr_i[XLEN-1:MEM_AW+2]};

    assign if_word_addr = bus.if_addr_i[MEM_AW+1:2];
    assign d_word_addr  = bus.d_addr_i[MEM_AW+1:2];

    // Fetch wins unless data is also asking and fetch was served last.
    assign grant_if = bus.if_req_i && (!bus.d_req_i || last_grant_data_q);
    assign grant_d  = bus.d_req_i && !grant_if;

    // Lane masks the SRAM can emulate with one read and one write.
    function automatic logic sel_is_partial(input logic [3:0] sel);
        logic ok;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [XLEN-1:0] merge_lanes(
        input logic [XLEN-1:0] new_word,
        input logic [XLEN-1:0] old_word,
        input logic [3:0]      sel
    );
        logic [XLEN-1:0] m;
        m = old_word;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                m[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            last_grant_data_q <= 1'b1;
            err_q             <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            sel_q             <= '0;
        end else begin
            state_q           <= state_d;
            last_grant_data_q <= last_grant_data_d;
            err_q             <= err_d;
            if (capture) begin
                addr_q  <= d_word_addr;
                wdata_q <= bus.d_wdata_i;
                sel_q   <= bus.d_sel_i;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        last_grant_data_d = last_grant_data_q;
        err_d             = err_q;
        capture           = 1'b0;
        ce                = 1'b0;
        we                = 1'b0;
        addr              = '0;
        wdata             = '0;
        if_ack            = 1'b0;
        if_rdata          = '0;
        d_ack             = 1'b0;
        d_err             = 1'b0;
        d_rdata           = '0;
        d_busy            = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    last_grant_data_d = 1'b0;
                    ce                = 1'b1;
                    addr              = if_word_addr;
                    state_d           = IF_RD;
                end else if (grant_d) begin
                    last_grant_data_d = 1'b1;
                    capture           = 1'b1;
                    if (!bus.d_we_i) begin
                        ce      = 1'b1;
                        addr    = d_word_addr;
                        state_d = D_RD;
                    end else begin
                        d_busy = 1'b1;
                        if (bus.d_sel_i == 4'b1111) begin
                            ce      = 1'b1;
                            we      = 1'b1;
                            addr    = d_word_addr;
                            wdata   = bus.d_wdata_i;
                            state_d = D_WACK;
                        end else if (sel_is_partial(bus.d_sel_i)) begin
                            // read phase of the read-modify-write
                            ce      = 1'b1;
                            addr    = d_word_addr;
                            state_d = D_RMW;
                        end else begin
                            err_d   = 1'b1;
                            state_d = D_WACK;
                        end
                    end
                end
            end

            IF_RD: begin
                if_ack   = 1'b1;
                if_rdata = bus.sram_rdata_i;
                state_d  = IDLE;
            end

            D_RD: begin
                d_ack   = 1'b1;
                d_rdata = bus.sram_rdata_i;
                state_d = IDLE;
            end

            D_RMW: begin
                d_busy  = 1'b1;
                ce      = 1'b1;
                we      = 1'b1;
                addr    = addr_q;
                wdata   = merge_lanes(wdata_q, bus.sram_rdata_i, sel_q);
                state_d = D_WACK;
            end

            D_WACK: begin
                d_ack   = 1'b1;
                d_err   = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are gated by rst_n so they drop to 0 the moment reset asserts,
    // which also suppresses an in-flight SRAM write before its clock edge.
    assign bus.sram_ce_o    = rst_n & ce;
    assign bus.sram_we_o    = rst_n & we;
    assign bus.sram_addr_o  = {MEM_AW{rst_n}} & addr;
    assign bus.sram_wdata_o = {XLEN{rst_n}} & wdata;
    assign bus.if_ack_o     = rst_n & if_ack;
    assign bus.if_rdata_o   = {XLEN{rst_n}} & if_rdata;
    assign bus.d_ack_o      = rst_n & d_ack;
    assign bus.d_err_o      = rst_n & d_err;
    assign bus.d_rdata_o    = {XLEN{rst_n}} & d_rdata;
    assign bus.d_busy_o     = rst_n & d_busy;

endmodule
